// File: rtl/idecode_stage.sv
// Decode stage: FIFO of fetched instructions, register file, load scoreboard.
// Ports: fetch handshake in, decoded operands out, writeback, flush, stall count; opt IDECODE_BYPASS_EN.
module idecode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int NREG  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rdata1,
    output logic [XLEN-1:0] out_rdata2,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [5:0]      out_opcode,
    output logic [5:0]      out_func,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic [15:0]     stall_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [31:0]     qi_q [DEPTH];
    logic [XLEN-1:0] qp_q [DEPTH];
    logic [XLEN-1:0] rf_q [NREG];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic [15:0]   stall_q, stall_d;

    logic            ov_q, ov_d;
    logic [XLEN-1:0] r1_q, r1_d;
    logic [XLEN-1:0] r2_q, r2_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [4:0]      ord_q, ord_d;
    logic [5:0]      op_q, op_d;
    logic [5:0]      fn_q, fn_d;

    logic [31:0]     head_inst;
    logic [XLEN-1:0] head_pc;
    logic [5:0]      opc;
    logic            is_j;
    logic            is_ld;
    logic            zext;
    logic [4:0]      rs, rt, rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rdata1, rdata2;
    logic            wb_hit_rs, wb_hit_rt;
    logic            rs_haz, rt_haz, hazard;
    logic            head_valid;
    logic            enq, issue;
    logic            unused_shamt;

    assign in_ready   = cnt_q < FULL;
    assign head_valid = cnt_q != '0;
    assign enq        = in_valid && in_ready && !flush;

    assign out_valid  = ov_q;
    assign out_rdata1 = r1_q;
    assign out_rdata2 = r2_q;
    assign out_imm    = imm_q;
    assign out_pc     = pc_q;
    assign out_rd     = ord_q;
    assign out_opcode = op_q;
    assign out_func   = fn_q;
    assign stall_cnt  = stall_q;

    // Field decode of the queue head.
    always_comb begin
        head_inst = qi_q[rd_ptr_q];
        head_pc   = qp_q[rd_ptr_q];
        opc       = head_inst[31:26];
        is_j      = (opc == 6'b000010) || (opc == 6'b000011);
        is_ld     = opc[5:3] == 3'b100;
        rs        = is_j ? 5'd0 : head_inst[25:21];
        rt        = (is_j || is_ld || opc == 6'b000001) ? 5'd0 : head_inst[20:16];
        rd        = 5'd0;
        unique case (1'b1)
            opc == 6'b000000:
                rd = head_inst[15:11];
            opc[5:3] == 3'b001 || is_ld:
                rd = head_inst[20:16];
            opc == 6'b000001 || opc == 6'b000011:
                rd = 5'd31;
            default:
                rd = 5'd0;
        endcase
        zext = (opc == 6'b001100) || (opc == 6'b001101) || (opc == 6'b001110);
        if (zext)
            imm = {{(XLEN-16){1'b0}}, head_inst[15:0]};
        else
            imm = {{(XLEN-16){head_inst[15]}}, head_inst[15:0]};
    end

    assign unused_shamt = ^head_inst[10:6];

    // Operand read and scoreboard hazard.
    always_comb begin
        wb_hit_rs = wb_we && (wb_rd == rs) && (rs != 5'd0);
        wb_hit_rt = wb_we && (wb_rd == rt) && (rt != 5'd0);
        rdata1    = (rs == 5'd0) ? '0 : rf_q[rs];
        rdata2    = (rt == 5'd0) ? '0 : rf_q[rt];
`ifdef IDECODE_BYPASS_EN
        if (wb_hit_rs)
            rdata1 = wb_data;
        if (wb_hit_rt)
            rdata2 = wb_data;
        rs_haz = (rs != 5'd0) && busy_q[rs] && !wb_hit_rs;
        rt_haz = (rt != 5'd0) && busy_q[rt] && !wb_hit_rt;
`else
        // Without forwarding a same-cycle writeback is not yet visible.
        rs_haz = (rs != 5'd0) && busy_q[rs];
        rt_haz = (rt != 5'd0) && busy_q[rt];
`endif
        hazard = rs_haz || rt_haz;
        issue  = head_valid && !hazard && (!ov_q || out_ready) && !flush;
    end

    // Next state for queue control, output register, busy bits, stall counter.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        stall_d  = stall_q;
        ov_d     = ov_q;
        r1_d     = r1_q;
        r2_d     = r2_q;
        imm_d    = imm_q;
        pc_d     = pc_q;
        ord_d    = ord_q;
        op_d     = op_q;
        fn_d     = fn_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
            busy_d   = '0;
            ov_d     = 1'b0;
        end else begin
            if (enq)
                wr_ptr_d = wr_ptr_q + PW'(1);
            if (issue)
                rd_ptr_d = rd_ptr_q + PW'(1);
            cnt_d = cnt_q + (PW+1)'(enq) - (PW+1)'(issue);

            if (head_valid && hazard && stall_q != 16'hFFFF)
                stall_d = stall_q + 16'd1;

            if (issue) begin
                ov_d  = 1'b1;
                r1_d  = rdata1;
                r2_d  = rdata2;
                imm_d = imm;
                pc_d  = head_pc;
                ord_d = rd;
                op_d  = opc;
                fn_d  = head_inst[5:0];
            end else if (out_ready) begin
                ov_d = 1'b0;
            end

            // Clear first so a load issued this cycle keeps ownership.
            for (int i = 0; i < NREG; i++) begin
                if (wb_we && wb_rd == 5'(i))
                    busy_d[i] = 1'b0;
                if (issue && is_ld && rd != 5'd0 && rd == 5'(i))
                    busy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            busy_q   <= '0;
            stall_q  <= '0;
            ov_q     <= 1'b0;
            r1_q     <= '0;
            r2_q     <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            ord_q    <= '0;
            op_q     <= '0;
            fn_q     <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            stall_q  <= stall_d;
            ov_q     <= ov_d;
            r1_q     <= r1_d;
            r2_q     <= r2_d;
            imm_q    <= imm_d;
            pc_q     <= pc_d;
            ord_q    <= ord_d;
            op_q     <= op_d;
            fn_q     <= fn_d;
        end
    end

    // Storage arrays carry no reset; validity lives in the pointers.
    always_ff @(posedge clk) begin
        if (enq) begin
            qi_q[wr_ptr_q] <= in_inst;
            qp_q[wr_ptr_q] <= in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (wb_we && wb_rd != 5'd0)
            rf_q[wb_rd] <= wb_data;
    end

endmodule

// File: tb/tb_idecode_stage.sv
// Randomised scoreboard bench for idecode_stage.
// Reference model is a queue-based rule model; monitor checks every cycle.
module tb_idecode_stage;

    localparam int DEPTH = 2;
`ifdef IDECODE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_rdata1, out_rdata2, out_imm, out_pc;
    logic [4:0]  out_rd;
    logic [5:0]  out_opcode, out_func;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        flush = 1'b0;
    logic [15:0] stall_cnt;

    idecode_stage #(.XLEN(32), .DEPTH(DEPTH), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rdata1(out_rdata1), .out_rdata2(out_rdata2),
        .out_imm(out_imm), .out_pc(out_pc),
        .out_rd(out_rd), .out_opcode(out_opcode), .out_func(out_func),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } qe_t;

    typedef struct {
        logic [31:0] r1, r2, imm, pc;
        logic [4:0]  rd;
        logic [5:0]  op, fn;
    } txn_t;

    qe_t         mq[$];
    txn_t        exp_q[$];
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          m_ov;
    int          m_stall;
    int          checks = 0;
    int          errors = 0;
    txn_t        mon_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] f_rs(input logic [31:0] i);
        if (i[31:26] == 6'd2 || i[31:26] == 6'd3) return 5'd0;
        return i[25:21];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] i);
        if (i[31:26] <= 6'd3 && i[31:26] != 6'd0) return 5'd0;
        if (i[31:29] == 3'b100) return 5'd0;
        return i[20:16];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] i);
        if (i[31:26] == 6'd0) return i[15:11];
        if (i[31:29] == 3'b001 || i[31:29] == 3'b100) return i[20:16];
        if (i[31:26] == 6'd1 || i[31:26] == 6'd3) return 5'd31;
        return 5'd0;
    endfunction

    function automatic logic [31:0] f_imm(input logic [31:0] i);
        if (i[31:26] >= 6'd12 && i[31:26] <= 6'd14) return {16'h0, i[15:0]};
        return {{16{i[15]}}, i[15:0]};
    endfunction

    function automatic bit fwd(input logic [4:0] r);
        return BYP && wb_we && wb_rd == r;
    endfunction

    function automatic bit blocked(input logic [4:0] r);
        return r != 0 && m_busy[r] && !fwd(r);
    endfunction

    function automatic logic [31:0] rdval(input logic [4:0] r);
        if (r == 0) return 32'h0;
        if (fwd(r)) return wb_data;
        return m_regs[r];
    endfunction

    task automatic step();
        bit rdy, haz, iss;
        logic [31:0] h;
        txn_t t;
        rdy = mq.size() < DEPTH;
        iss = 0;
        h = '0;
        if (flush) begin
            mq.delete();
            exp_q.delete();
            m_ov = 0;
            foreach (m_busy[i]) m_busy[i] = 0;
        end else begin
            if (mq.size() > 0) begin
                h = mq[0].inst;
                haz = blocked(f_rs(h)) || blocked(f_rt(h));
                if (haz && m_stall < 16'hFFFF) m_stall++;
                iss = !haz && (!m_ov || out_ready);
            end
            if (iss) begin
                t.r1 = rdval(f_rs(h));
                t.r2 = rdval(f_rt(h));
                t.imm = f_imm(h);
                t.pc = mq[0].pc;
                t.rd = f_rd(h);
                t.op = h[31:26];
                t.fn = h[5:0];
                exp_q.push_back(t);
                void'(mq.pop_front());
                m_ov = 1;
            end else if (out_ready) begin
                m_ov = 0;
            end
            if (wb_we && wb_rd != 0) m_busy[wb_rd] = 0;
            if (iss && h[31:29] == 3'b100 && f_rd(h) != 0) m_busy[f_rd(h)] = 1;
            if (rdy && in_valid) mq.push_back('{inst: in_inst, pc: in_pc});
        end
        if (wb_we && wb_rd != 0) m_regs[wb_rd] = wb_data;
    endtask

    initial begin
        foreach (m_regs[i]) m_regs[i] = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                exp_q.delete();
                m_ov = 0;
                m_stall = 0;
                foreach (m_busy[i]) m_busy[i] = 0;
            end else begin
                step();
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, mq.size() < DEPTH);
            chk("out_valid", out_valid, m_ov);
            chk("stall_cnt", stall_cnt, m_stall);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    mon_t = exp_q[0];
                    chk("rdata1", out_rdata1, mon_t.r1);
                    chk("rdata2", out_rdata2, mon_t.r2);
                    chk("imm", out_imm, mon_t.imm);
                    chk("pc", out_pc, mon_t.pc);
                    chk("rd", out_rd, mon_t.rd);
                    chk("opcode", out_opcode, mon_t.op);
                    chk("func", out_func, mon_t.fn);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] p, input int maxw);
        bit acc;
        in_inst = i;
        in_pc = p;
        in_valid = 1'b1;
        for (int k = 0; k < maxw; k++) begin
            acc = in_ready;
            cyc();
            if (acc) break;
        end
        in_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        wb_we = 1'b1;
        wb_rd = r;
        wb_data = d;
        cyc();
        wb_we = 1'b0;
    endtask

    function automatic logic [31:0] rnd_inst();
        logic [31:0] r;
        logic [5:0] op;
        r = $urandom;
        case ($urandom % 6)
            0: op = 6'd0;
            1: op = {3'b100, 3'($urandom % 8)};
            2: op = {3'b001, 3'($urandom % 8)};
            3: op = 6'($urandom % 4);
            4: op = 6'(12 + $urandom % 3);
            default: op = 6'($urandom % 64);
        endcase
        r[31:26] = op;
        r[25:21] = 5'($urandom % 8);
        r[20:16] = 5'($urandom % 8);
        r[15:11] = 5'($urandom % 8);
        if ($urandom % 16 == 0) r = '0;
        return r;
    endfunction

    int s0;

    initial begin
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_rdata1", out_rdata1, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int r = 1; r < 32; r++) wb(5'(r), $urandom);

        // addu r3,r5,r0 after r5 written
        out_ready = 1'b1;
        wb(5'd5, 32'h1234);
        push(32'h00A01821, 32'h100, 4);
        cyc();
        chk("t031_valid", out_valid, 1);
        chk("t031_rdata1", out_rdata1, 32'h1234);
        chk("t031_rd", out_rd, 3);

        // fill with output blocked
        out_ready = 1'b0;
        for (int k = 0; k < DEPTH + 2; k++)
            push({6'd0, 5'(k + 1), 5'(k + 2), 5'(k + 10), 11'h021}, 32'(k * 4), 4);
        chk("t032_full", in_ready, 0);
        out_ready = 1'b1;
        repeat (6) cyc();

        // load-use stall then writeback
        push(32'h8C880000, 32'h200, 4);
        push(32'h01084821, 32'h204, 4);
        s0 = m_stall;
        repeat (5) cyc();
        chk("t033_stalled", stall_cnt > 16'(s0), 1);
        chk("t033_held", out_rd, 8);
        wb(5'd8, 32'd7);
        cyc();
        chk("t033_rdata1", out_rdata1, 7);
        chk("t033_rdata2", out_rdata2, 7);
        chk("t033_rd", out_rd, 9);

        // zero vs sign extension
        push(32'h30228000, 32'h300, 4);
        push(32'h20228000, 32'h304, 4);
        chk("t034_andi", out_imm, 32'h00008000);
        cyc();
        chk("t034_addi", out_imm, 32'hFFFF8000);
        repeat (2) cyc();

        // flush with busy r8 and a full queue
        out_ready = 1'b0;
        push(32'h8C880000, 32'h400, 4);
        push(32'h00221821, 32'h404, 4);
        push(32'h00221821, 32'h408, 4);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("t035_valid", out_valid, 0);
        chk("t035_ready", in_ready, 1);
        s0 = m_stall;
        out_ready = 1'b1;
        push(32'h01084821, 32'h40C, 4);
        cyc();
        chk("t035_issued", out_valid, 1);
        chk("t035_nostall", stall_cnt, 16'(s0));
        cyc();

        // async reset while output is held
        out_ready = 1'b0;
        push(32'h00A01821, 32'h500, 4);
        cyc();
        chk("t036_pre", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t036_valid", out_valid, 0);
        chk("t036_stall", stall_cnt, 0);
        chk("t036_ready", in_ready, 1);
        cyc();
        rst_n = 1'b1;

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid = 1'($urandom % 2);
            in_inst = rnd_inst();
            in_pc = $urandom;
            out_ready = ($urandom % 4) != 0;
            wb_we = ($urandom % 3) == 0;
            wb_rd = 5'($urandom % 8);
            wb_data = $urandom;
            flush = ($urandom % 64) == 0;
            cyc();
        end

        // drain: release every register
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (mq.size() == 0 && exp_q.size() == 0 && !m_ov) break;
            wb_we = 1'b1;
            wb_rd = 5'(k % 32);
            wb_data = $urandom;
            cyc();
        end
        wb_we = 1'b0;
        cyc();
        chk("drain_left", mq.size() + exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/idecode_stage.md
IDECODE_STAGE -- requirements
Module: idecode_stage

Interface
REQ-001 Parameter XLEN, default 32: datapath width of register data, PC and immediate; instruction stays 32 bits.
REQ-002 Parameter DEPTH, default 2: instruction queue entries, a power of two and at least 2.
REQ-003 Parameter NREG, default 32: number of architectural registers; register index width is 5.
REQ-004 Port clk, input, 1: single clock, all state on the rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Ports in_valid/in_ready, input/output, 1/1: fetch-side handshake.
REQ-007 Ports in_inst/in_pc, input, 32/XLEN: fetched instruction and its PC.
REQ-008 Ports out_valid/out_ready, output/input, 1/1: execute-side handshake.
REQ-009 Ports out_rdata1/out_rdata2/out_imm/out_pc, output, XLEN each: decoded operands and PC.
REQ-010 Ports out_rd/out_opcode/out_func, output, 5/6/6: destination register, inst[31:26], inst[5:0].
REQ-011 Ports wb_we/wb_rd/wb_data, input, 1/5/XLEN: register writeback port.
REQ-012 Port flush, input, 1: synchronous discard of all in-flight work.
REQ-013 Port stall_cnt, output, 16: count of cycles stalled on the scoreboard.

Function
REQ-014 Enqueue on in_valid&&in_ready; in_ready = (queue count < DEPTH); order is FIFO, pointers wrap modulo DEPTH.
REQ-015 Source fields: rs = 0 for opcode 000010/000011, else inst[25:21]; rt = 0 for opcode 000001/000010/000011 or opcode[5:3]=100, else inst[20:16].
REQ-016 Destination: inst[15:11] for opcode 000000; inst[20:16] for opcode[5:3] 001 or 100; 31 for opcode 000001 or 000011; otherwise 0.
REQ-017 Immediate: zero-extend inst[15:0] for opcodes 001100/001101/001110; sign-extend inst[15:0] to XLEN for all others.
REQ-018 Register file: NREG x XLEN, two asynchronous read ports; register 0 reads 0 and ignores writes; a write occurs at the edge when wb_we=1.
REQ-019 Issue = queue head valid && no scoreboard hazard && (!out_valid || out_ready); on issue, all out_* register the decoded head and the head pops.
REQ-020 out_* hold stable while out_valid && !out_ready; out_valid clears after a transfer with no new issue.
REQ-021 Scoreboard: NREG busy bits; an issued instruction with opcode[5:3]=100 and rd!=0 sets busy[rd]; wb_we with wb_rd=that index clears it.
REQ-022 Hazard: head's nonzero rs or rt has its busy bit set and is not cleared by wb in the same cycle; a hazard blocks issue and stall_cnt increments, saturating at 16'hFFFF.
REQ-023 Set and clear of the same busy bit in the same cycle: set wins (the new load owns the register).
REQ-024 Encoding 32'h0 issues with out_rd = 0 and never sets busy.
REQ-025 Flush: queue emptied, out_valid cleared, all busy bits cleared, in_ready=1 next cycle; an enqueue attempted in the flush cycle is dropped; the regfile and stall_cnt are unchanged.
REQ-026 Simultaneous enqueue and pop with a full queue is permitted only when in_ready was 1 (no bypass of the full check).

Reset
REQ-027 rst_n low asynchronously clears queue pointers/count, out_valid, all out_* to 0, busy bits, and stall_cnt; in_ready=1 after reset; regfile contents are not reset.
REQ-028 Reset asserted mid-transfer aborts it; no partial state survives deassertion.

Configuration
REQ-029 Macro IDECODE_BYPASS_EN defined: a read of register r in the issue cycle with wb_we && wb_rd==r && r!=0 returns wb_data.
REQ-030 Macro IDECODE_BYPASS_EN undefined: reads return the pre-write regfile value, and the hazard check also treats a same-cycle clear as still busy.

Verification
REQ-031 Reset, write wb r5=32'h1234, enqueue addu r3,r5,r0 (32'h00A01821) -> next cycle out_valid=1, out_rdata1=32'h1234, out_rd=3.
REQ-032 Hold out_ready=0 and push DEPTH+1 instructions -> in_ready=0 after DEPTH, out_* stable; release -> drains in order with no loss.
REQ-033 Issue lw r8,0(r4) then addu r9,r8,r8 -> 2nd held, stall_cnt counts; wb r8=7 -> issues with 7 with bypass (one cycle later without).
REQ-034 Enqueue andi with imm 16'h8000 and addi with imm 16'h8000 -> out_imm = 32'h00008000 and 32'hFFFF8000 respectively.
REQ-035 Flush with 2 queued, 1 on output, r8 busy -> next cycle out_valid=0, in_ready=1, a use of r8 issues without stall.
REQ-036 Assert rst_n low between edges while out_valid=1 -> out_valid drops immediately, stall_cnt=0.
